// File: rtl/disp_pkg.sv
// Shared constants, glyph table and FSM encoding for the add/sub 7-segment display path.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_e;

  // Active-low {a,b,c,d,e,f,g}; codes above 9 cannot occur and map to blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_disp_mux_if.sv
// Operand inputs and display pin outputs of the add/sub display block.
interface addsub_disp_mux_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned N_BCD = 3
);
  logic signed [W-1:0] A;
  logic signed [W-1:0] B;
  logic                OP;
  logic [6:0]          SEG;
  logic [N_BCD:0]      AN;
  logic                BUSY;

  modport master (output A, B, OP, input SEG, AN, BUSY);
  modport slave  (input A, B, OP, output SEG, AN, BUSY);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: i_start loads the binary value, then one bit per cycle.
module bin2bcd_seq #(
  parameter int unsigned W     = 8,
  parameter int unsigned N_BCD = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [W:0]       i_bin,
  output logic             o_done,
  output logic [4*N_BCD-1:0] o_bcd
);

  localparam int unsigned BW   = W + 1;
  localparam int unsigned BCDW = 4 * N_BCD;
  localparam int unsigned CW   = $clog2(BW + 1);

  logic [BW-1:0]   r_bin;
  logic [BCDW-1:0] r_bcd;
  logic [CW-1:0]   r_cnt;
  logic [BCDW-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < int'(N_BCD); i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CW'(BW);
    end else if (r_cnt != '0) begin
      r_bcd <= BCDW'({w_adj, r_bin[BW-1]});
      r_bin <= {r_bin[BW-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // High during the final shift cycle, so o_bcd is complete on the following cycle.
  assign o_done = (r_cnt == CW'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/addsub_disp_mux.sv
// Signed add/sub of two operands shown on a multiplexed common-anode 7-segment display.
module addsub_disp_mux #(
  parameter int unsigned W           = 8,
  parameter int unsigned N_BCD       = 3,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input logic               CLK,
  input logic               RST_N,
  addsub_disp_mux_if.slave  io_bus
);

  import disp_pkg::*;

  localparam int unsigned CNTW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDXW = (N_BCD > 0) ? $clog2(N_BCD + 1) : 1;

  if (pow10(N_BCD) <= (64'd1 << W)) begin : g_bad_bcd
    $error("N_BCD digits cannot hold the largest magnitude 2^W");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be at least 2");
  end

  logic [W:0]               w_a_ext, w_b_ext, w_res, w_mag;
  logic                     w_sign;
  logic                     w_start, w_done;
  logic [4*N_BCD-1:0]       w_bcd;
  logic [N_BCD:0]           w_show;
  logic                     w_any_nz;
  logic [N_BCD:0][6:0]      w_pat, w_disp_d;
  logic                     w_tick;
  logic [IDXW-1:0]          w_idx_d;

  state_e                   r_state;
  logic                     r_sign, r_busy;
  logic [N_BCD:0][6:0]      r_disp;
  logic [CNTW-1:0]          r_ref_cnt;
  logic [IDXW-1:0]          r_idx;
  logic [N_BCD:0]           r_an;
  logic [6:0]               r_seg;

  // W+1 bit arithmetic cannot overflow; the magnitude of -2^W still fits unsigned.
  assign w_a_ext = {io_bus.A[W-1], io_bus.A};
  assign w_b_ext = {io_bus.B[W-1], io_bus.B};
  assign w_res   = io_bus.OP ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
  assign w_sign  = w_res[W];
  assign w_mag   = w_sign ? -w_res : w_res;
  assign w_start = (r_state == LOAD);

  bin2bcd_seq #(
    .W     (W),
    .N_BCD (N_BCD)
  ) u_bin2bcd (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_start (w_start),
    .i_bin   (w_mag),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Sign lands just above the highest shown digit; with blanking off that is always N_BCD.
  always_comb begin
    w_any_nz = 1'b0;
    w_show   = '0;
    for (int i = int'(N_BCD) - 1; i >= 0; i--) begin
      w_any_nz  = w_any_nz | (w_bcd[4*i +: 4] != 4'd0);
      w_show[i] = w_any_nz || (i == 0) || (BLANK_LZ == 0);
    end
    w_pat = {(N_BCD + 1){SEG_BLANK}};
    for (int p = 0; p < int'(N_BCD); p++) begin
      if (w_show[p]) begin
        w_pat[p] = bcd_to_seg(w_bcd[4*p +: 4]);
      end
    end
    for (int p = 1; p <= int'(N_BCD); p++) begin
      if (r_sign && w_show[p-1] && !w_show[p]) begin
        w_pat[p] = SEG_MINUS;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_busy  <= 1'b0;
      r_disp  <= {(N_BCD + 1){SEG_BLANK}};
    end else begin
      case (r_state)
        IDLE: r_state <= LOAD;
        LOAD: begin
          r_sign  <= w_sign;
          r_busy  <= 1'b1;
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_done) r_state <= COMMIT;
        end
        COMMIT: begin
          r_disp  <= w_pat;
          r_busy  <= 1'b0;
          r_state <= LOAD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_disp_d = (r_state == COMMIT) ? w_pat : r_disp;
  assign w_tick   = (r_ref_cnt == CNTW'(REFRESH_DIV - 1));

  always_comb begin
    w_idx_d = r_idx;
    if (w_tick) begin
      w_idx_d = (r_idx == IDXW'(N_BCD)) ? '0 : r_idx + IDXW'(1);
    end
  end

  // AN and SEG both come from the next index so they switch on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ref_cnt <= '0;
      r_idx     <= '0;
      r_an      <= '1;
      r_seg     <= SEG_BLANK;
    end else begin
      r_ref_cnt <= w_tick ? '0 : r_ref_cnt + CNTW'(1);
      r_idx     <= w_idx_d;
      r_an      <= ~({{N_BCD{1'b0}}, 1'b1} << w_idx_d);
      r_seg     <= w_disp_d[w_idx_d];
    end
  end

  assign io_bus.SEG  = r_seg;
  assign io_bus.AN   = r_an;
  assign io_bus.BUSY = r_busy;

endmodule

// File: tb/tb_addsub_disp_mux.sv
// Bench for addsub_disp_mux: two DUTs (blanking on/off) in lockstep against a decimal display model.
module tb_addsub_disp_mux;

  localparam int W    = 8;
  localparam int N    = 3;
  localparam int DIV  = 4;
  localparam int PER  = W + 3;
  localparam int HIST = 2048;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0000100, GB = 7'b1111111, GM = 7'b1111110;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  addsub_disp_mux_if #(.W(W), .N_BCD(N)) bus1 ();
  addsub_disp_mux_if #(.W(W), .N_BCD(N)) bus0 ();

  addsub_disp_mux #(.W(W), .N_BCD(N), .REFRESH_DIV(DIV), .BLANK_LZ(1)) dut1 (
    .CLK    (clk),
    .RST_N  (rst_n),
    .io_bus (bus1)
  );
  addsub_disp_mux #(.W(W), .N_BCD(N), .REFRESH_DIV(DIV), .BLANK_LZ(0)) dut0 (
    .CLK    (clk),
    .RST_N  (rst_n),
    .io_bus (bus0)
  );

  int errors = 0;
  int checks = 0;
  int k = 0;
  logic [7:0] cur_a, cur_b;
  logic       cur_op;
  logic [7:0] hist_a [HIST];
  logic [7:0] hist_b [HIST];
  logic       hist_op [HIST];

  typedef struct packed {
    logic [7:0]      a;
    logic [7:0]      b;
    logic            op;
    logic [3:0][6:0] lz1;
    logic [3:0][6:0] lz0;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h, want %0h", name, k, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return G0;  1: return G1;  2: return G2;  3: return G3;  4: return G4;
      5: return G5;  6: return G6;  7: return G7;  8: return G8;  default: return G9;
    endcase
  endfunction

  function automatic int sval(input logic [7:0] a, input logic [7:0] b, input logic op);
    int av = int'($signed(a));
    int bv = int'($signed(b));
    return op ? av - bv : av + bv;
  endfunction

  // Decimal rendering of v at position p, straight from the display rules.
  function automatic logic [6:0] exp_seg(input int v, input int p, input bit blz);
    int mag = (v < 0) ? -v : v;
    int msd = 0;
    int sp;
    int d [N];
    for (int i = 0; i < N; i++) begin
      d[i] = mag % 10;
      mag  = mag / 10;
      if (d[i] != 0) msd = i;
    end
    if (p < N && (!blz || p <= msd)) return glyph(d[p]);
    sp = blz ? msd + 1 : N;
    return (p == sp && v < 0) ? GM : GB;
  endfunction

  // Commits land W+4 edges after reset and every W+3 edges after that, from operands seen W+2 earlier.
  function automatic logic [6:0] model_seg(input int p, input bit blz);
    int m, ks;
    if (k < W + 4) return GB;
    m  = (k - (W + 4)) / PER;
    ks = 2 + m * PER;
    return exp_seg(sval(hist_a[ks], hist_b[ks], hist_op[ks]), p, blz);
  endfunction

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic op);
    cur_a = a;  cur_b = b;  cur_op = op;
    bus1.A = a; bus1.B = b; bus1.OP = op;
    bus0.A = a; bus0.B = b; bus0.OP = op;
  endtask

  task automatic step();
    int idx;
    logic [3:0] exp_an;
    logic exp_busy;
    if (k + 1 < HIST) begin
      hist_a[k+1] = cur_a; hist_b[k+1] = cur_b; hist_op[k+1] = cur_op;
    end
    @(posedge clk);
    k++;
    #1;
    idx      = (k / DIV) % (N + 1);
    exp_an   = ~(4'b0001 << idx);
    exp_busy = (k >= 2) && (((k - 2) % PER) != PER - 1);
    check("an_lz1",   32'(bus1.AN),   32'(exp_an));
    check("an_lz0",   32'(bus0.AN),   32'(exp_an));
    check("seg_lz1",  32'(bus1.SEG),  32'(model_seg(idx, 1'b1)));
    check("seg_lz0",  32'(bus0.SEG),  32'(model_seg(idx, 1'b0)));
    check("busy_lz1", 32'(bus1.BUSY), 32'(exp_busy));
    check("busy_lz0", 32'(bus0.BUSY), 32'(exp_busy));
  endtask

  // Asserts reset away from any edge, checks the async values, holds one edge, releases mid-cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_seg1",  32'(bus1.SEG),  32'(GB));
    check("rst_an1",   32'(bus1.AN),   32'hF);
    check("rst_busy1", 32'(bus1.BUSY), 32'h0);
    check("rst_seg0",  32'(bus0.SEG),  32'(GB));
    check("rst_an0",   32'(bus0.AN),   32'hF);
    check("rst_busy0", 32'(bus0.BUSY), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    k = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{a: 8'd100,  b: 8'd56,   op: 1'b0, lz1: {GB, G1, G5, G6}, lz0: {GB, G1, G5, G6}};
    tbl[1] = '{a: 8'd5,    b: 8'd10,   op: 1'b1, lz1: {GB, GB, GM, G5}, lz0: {GM, G0, G0, G5}};
    tbl[2] = '{a: 8'h80,   b: 8'h80,   op: 1'b0, lz1: {GM, G2, G5, G6}, lz0: {GM, G2, G5, G6}};
    tbl[3] = '{a: 8'h80,   b: 8'h7F,   op: 1'b1, lz1: {GM, G2, G5, G5}, lz0: {GM, G2, G5, G5}};
    tbl[4] = '{a: 8'd0,    b: 8'd0,    op: 1'b0, lz1: {GB, GB, GB, G0}, lz0: {GB, G0, G0, G0}};
    tbl[5] = '{a: 8'h7F,   b: 8'h7F,   op: 1'b0, lz1: {GB, G2, G5, G4}, lz0: {GB, G2, G5, G4}};
    tbl[6] = '{a: 8'd0,    b: 8'd10,   op: 1'b1, lz1: {GB, GM, G1, G0}, lz0: {GM, G0, G1, G0}};

    set_ops(8'd0, 8'd0, 1'b0);
    #1;
    do_reset();

    // Table of known display patterns, scanned position by position.
    for (int i = 0; i < 7; i++) begin
      set_ops(tbl[i].a, tbl[i].b, tbl[i].op);
      repeat (2 * PER + 2) step();
      for (int p = 0; p <= N; p++) begin
        logic [3:0] want_an;
        int n;
        want_an = ~(4'b0001 << p);
        n = 0;
        while (bus1.AN !== want_an && n < 20) begin
          step();
          n++;
        end
        if (n >= 20) begin
          checks++;
          errors++;
          $display("FAIL scan_timeout vec=%0d pos=%0d: got AN %b, want %b", i, p, bus1.AN, want_an);
        end else begin
          check("tbl_seg_lz1", 32'(bus1.SEG), 32'(tbl[i].lz1[p]));
          check("tbl_seg_lz0", 32'(bus0.SEG), 32'(tbl[i].lz0[p]));
        end
      end
    end

    // Reset in the middle of SHIFT, then the first commit after release.
    do_reset();
    set_ops(8'd5, 8'd10, 1'b1);
    while (k < 5) step();
    do_reset();
    step();
    check("idx_restart", 32'(bus1.AN), 32'hE);
    while (k < W + 3) step();
    check("pre_commit_lz0", 32'(bus0.SEG), 32'(GB));
    step();
    check("first_valid_lz0", 32'(bus0.SEG), 32'(GM));
    check("first_valid_an0", 32'(bus0.AN),  32'h7);

    // Operand change during SHIFT only shows after the next full conversion.
    do_reset();
    set_ops(8'd100, 8'd56, 1'b0);
    while (k < 5) step();
    set_ops(8'd20, 8'd56, 1'b0);
    while (k < 2 * PER) step();
    check("hold_old_an", 32'(bus1.AN),  32'hD);
    check("hold_old",    32'(bus1.SEG), 32'(G5));
    step();
    check("new_value",   32'(bus1.SEG), 32'(G7));

    // Random operands against the model.
    do_reset();
    for (int it = 0; it < 150; it++) begin
      set_ops(8'($urandom()), 8'($urandom()), 1'($urandom()));
      repeat ($urandom_range(1, 14)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
